// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants (state enum, reset PC, NOP encoding).
// Also used by the PC register and the testbench.
package if_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PC_STEP    = 4;

  localparam logic [DATA_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC  = 32'h0040_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

  // Sequential PC successor, wrapping modulo 2^32.
  function automatic logic [ADDR_W_DEF-1:0] pc_next(input logic [ADDR_W_DEF-1:0] pc);
    return pc + ADDR_W_DEF'(PC_STEP);
  endfunction

endpackage : if_pkg

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  // Fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface : if_fetch_stage_if

// File: rtl/if_hold_buf.sv
// One-entry pc/instruction skid buffer used while ID is stalled.
module if_hold_buf #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] instr_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;

  // Clear dominates; a load into a full buffer cannot occur (the FSM is in HOLD).
  always_ff @(posedge clk) begin
    if (clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule : if_hold_buf

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: issues imem requests, absorbs wait states and
// ID stalls, drives IF/ID. Optional perf counters under IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(if_pkg::NOP_INSTR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc_in,
  if_fetch_stage_if.master    imem,
  input  logic                stall_id,
  input  logic                flush,
  output logic                pc_hold,
  output logic                id_valid,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [ADDR_W-1:0]   id_pc_plus4,
  output logic [DATA_W-1:0]   id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  import if_pkg::*;

  if_state_e         state_q;
  logic              id_valid_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [ADDR_W-1:0] id_pc_plus4_q;
  logic [DATA_W-1:0] id_instr_q;

  logic              buf_load;
  logic              buf_drain;
  logic              buf_clear;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [DATA_W-1:0] buf_instr;
  logic              in_fetch;
  logic              in_hold;

  assign in_fetch = (state_q == FETCH);
  assign in_hold  = (state_q == HOLD);

  // Memory request is only live in FETCH; ack with no request is ignored.
  assign imem.imem_req  = !rst && in_fetch;
  assign imem.imem_addr = pc_in;

  always_comb begin
    pc_hold = 1'b1;
    if (rst)
      pc_hold = 1'b1;
    else if (flush)
      pc_hold = 1'b0;
    else if (in_hold)
      pc_hold = 1'b1;
    else
      pc_hold = !imem.imem_ack;
  end

  assign buf_clear = rst || flush;
  assign buf_load  = !rst && !flush && in_fetch && imem.imem_ack && stall_id;
  assign buf_drain = !rst && !flush && in_hold && !stall_id && buf_valid;

  if_hold_buf #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_hold_buf (
    .clk     (clk),
    .clear_i (buf_clear),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .pc_i    (pc_in),
    .instr_i (imem.imem_rdata),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .instr_o (buf_instr)
  );

  // FSM and IF/ID register; flush outranks stall and ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= NOP_INSTR;
    end else if (flush) begin
      state_q    <= FETCH;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            if (!stall_id) begin
              id_valid_q    <= 1'b1;
              id_pc_q       <= pc_in;
              id_pc_plus4_q <= pc_in + ADDR_W'(PC_STEP);
              id_instr_q    <= imem.imem_rdata;
            end else begin
              state_q <= HOLD;
            end
          end else if (!stall_id) begin
            id_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_id) begin
            state_q       <= FETCH;
            id_valid_q    <= buf_valid;
            id_pc_q       <= buf_pc;
            id_pc_plus4_q <= buf_pc + ADDR_W'(PC_STEP);
            id_instr_q    <= buf_instr;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (imem.imem_req && imem.imem_ack && !flush)
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (pc_hold)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage (perf counters checked when
// IF_PERF_CNT_EN is defined).
module tb_if_fetch_stage;

  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall_id;
  logic        flush;
  logic        pc_hold;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  if_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem ();

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .imem        (imem),
    .stall_id    (stall_id),
    .flush       (flush),
    .pc_hold     (pc_hold),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic ack, input logic stall,
                       input logic fl, input logic [31:0] rdata);
    pc_in            = pc;
    imem.imem_ack    = ack;
    stall_id         = stall;
    flush            = fl;
    imem.imem_rdata  = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic req, input logic hold);
    chk({tag, "_req"},  32'(imem.imem_req), 32'(req));
    chk({tag, "_hold"}, 32'(pc_hold), 32'(hold));
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(id_valid), 32'(v));
    chk({tag, "_pc"},    id_pc, pc);
    chk({tag, "_pc4"},   id_pc_plus4, pc4);
    chk({tag, "_instr"}, id_instr, instr);
  endtask

  initial begin
    rst = 1'b1;
    drive(RESET_PC, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_comb("rst", 1'b0, 1'b1);
    chk_id("rst", 1'b0, 32'h0, 32'h0, 32'h0);

    // Back-to-back fetches with ack every cycle.
    rst = 1'b0;
    drive(32'h0040_0000, 1'b1, 1'b0, 1'b0, 32'h1111_1111);
    chk_comb("f0", 1'b1, 1'b0);
    chk("f0_addr", imem.imem_addr, 32'h0040_0000);
    tick();
    chk_id("f0", 1'b1, 32'h0040_0000, 32'h0040_0004, 32'h1111_1111);
    drive(32'h0040_0004, 1'b1, 1'b0, 1'b0, 32'h2222_2222);
    chk_comb("f1", 1'b1, 1'b0);
    tick();
    chk_id("f1", 1'b1, 32'h0040_0004, 32'h0040_0008, 32'h2222_2222);

    // Two wait states then ack.
    drive(32'h0040_0008, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_comb("w0", 1'b1, 1'b1);
    tick();
    chk("w0_valid", 32'(id_valid), 32'd0);
    drive(32'h0040_0008, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_comb("w1", 1'b1, 1'b1);
    tick();
    chk("w1_valid", 32'(id_valid), 32'd0);
    drive(32'h0040_0008, 1'b1, 1'b0, 1'b0, 32'h3333_3333);
    chk_comb("w2", 1'b1, 1'b0);
    tick();
    chk_id("w2", 1'b1, 32'h0040_0008, 32'h0040_000C, 32'h3333_3333);

    // Ack under a 3-cycle ID stall: word buffered, IF/ID frozen.
    drive(32'h0040_000C, 1'b1, 1'b1, 1'b0, 32'h4444_4444);
    chk_comb("s0", 1'b1, 1'b0);
    tick();
    chk_id("s0", 1'b1, 32'h0040_0008, 32'h0040_000C, 32'h3333_3333);
    drive(32'h0040_0010, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_comb("s1", 1'b0, 1'b1);
    tick();
    chk_id("s1", 1'b1, 32'h0040_0008, 32'h0040_000C, 32'h3333_3333);
    drive(32'h0040_0010, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_comb("s2", 1'b0, 1'b1);
    tick();
    chk_id("s2", 1'b1, 32'h0040_0008, 32'h0040_000C, 32'h3333_3333);
    drive(32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_comb("s3", 1'b0, 1'b1);
    tick();
    chk_id("s3", 1'b1, 32'h0040_000C, 32'h0040_0010, 32'h4444_4444);
    drive(32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h5555_5555);
    chk_comb("s4", 1'b1, 1'b0);
    tick();
    chk_id("s4", 1'b1, 32'h0040_0010, 32'h0040_0014, 32'h5555_5555);

    // Flush while holding a buffered word.
    drive(32'h0040_0014, 1'b1, 1'b1, 1'b0, 32'h6666_6666);
    tick();
    drive(32'h0040_0018, 1'b0, 1'b1, 1'b1, 32'h0);
    chk_comb("fh", 1'b0, 1'b0);
    tick();
    chk("fh_valid", 32'(id_valid), 32'd0);
    chk("fh_instr", id_instr, 32'h0);
    drive(32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h7777_7777);
    chk_comb("fh_rs", 1'b1, 1'b0);
    chk("fh_addr", imem.imem_addr, 32'h0040_0100);
    tick();
    chk_id("fh_rs", 1'b1, 32'h0040_0100, 32'h0040_0104, 32'h7777_7777);

    // Flush + ack + stall in the same cycle: flush wins, nothing buffered.
    drive(32'h0040_0104, 1'b1, 1'b1, 1'b1, 32'h8888_8888);
    chk_comb("fas", 1'b1, 1'b0);
    tick();
    chk("fas_valid", 32'(id_valid), 32'd0);
    chk("fas_instr", id_instr, 32'h0);
    drive(32'h0040_0200, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_comb("fas_st", 1'b1, 1'b1);
    tick();
    chk("fas_st_valid", 32'(id_valid), 32'd0);
    drive(32'h0040_0200, 1'b1, 1'b0, 1'b0, 32'h9999_9999);
    tick();
    chk_id("fas_rs", 1'b1, 32'h0040_0200, 32'h0040_0204, 32'h9999_9999);

    // PC+4 wraps at the top of the address space.
    drive(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA);
    tick();
    chk_id("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hAAAA_AAAA);

    // Reset while in HOLD drops the buffered word.
    drive(32'h0040_0300, 1'b1, 1'b1, 1'b0, 32'hBBBB_BBBB);
    tick();
    rst = 1'b1;
    drive(32'h0040_0304, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_comb("rh", 1'b0, 1'b1);
    tick();
    chk_id("rh", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    drive(32'h0040_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_comb("rh_st", 1'b1, 1'b1);
    tick();
    chk("rh_st_valid", 32'(id_valid), 32'd0);

`ifdef IF_PERF_CNT_EN
    // 10 accepted fetches and 4 wait cycles after a fresh reset.
    rst = 1'b1;
    drive(RESET_PC, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("perf_rst_f", perf_fetch_cnt, 32'd0);
    chk("perf_rst_s", perf_stall_cnt, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(RESET_PC + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(RESET_PC + 32'd40, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk("perf_fetch", perf_fetch_cnt, 32'd10);
    chk("perf_stall", perf_stall_cnt, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_if_fetch_stage
